// File: rtl/regfile_pkg.sv
// Shared register-file types and sizes for the writeback path.
package regfile_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]   reg_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts at rr_ptr, pointer
// moves just past the winner whenever a grant is taken.
module rr_arbiter #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] rr_ptr;
  logic [PW-1:0] gidx;
  logic          found;
  int            idx;

  // Rotating priority search: first requester at or after rr_ptr wins
  always_comb begin
    grant = '0;
    gidx  = rr_ptr;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  // Pointer advances past the winner; holds when nothing is granted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (advance && found) begin
      if (int'(gidx) == N - 1) rr_ptr <= '0;
      else                     rr_ptr <= gidx + 1'b1;
    end
  end
endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter for the single register-file write port, with the
// registered write stage and the busy scoreboard used by issue to stall.
module regfile_wb_arbiter #(
  parameter int N_REQ = 2,
  parameter int XLEN  = 32
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_REQ-1:0]                       req_valid,
  output logic [N_REQ-1:0]                       req_ready,
  input  logic [N_REQ-1:0][regfile_pkg::REG_AW-1:0] req_rd,
  input  logic [N_REQ-1:0][XLEN-1:0]             req_data,
  output logic                                   rf_we,
  output logic [regfile_pkg::REG_AW-1:0]         rf_rd_addr,
  output logic [XLEN-1:0]                        rf_wdata,
  input  logic                                   issue_valid,
  input  logic [regfile_pkg::REG_AW-1:0]         issue_rd,
  output logic                                   issue_stall,
  output logic [regfile_pkg::NUM_REGS-1:0]       busy
);
  import regfile_pkg::*;

  logic                xfer;
  reg_addr_t           sel_rd;
  logic [XLEN-1:0]     sel_data;
  logic                issue_set;
  logic [NUM_REGS-1:0] busy_nxt;

  // Ready depends only on valid and the rotating pointer: the output
  // stage never backpressures, so every grant is a completed transfer.
  rr_arbiter #(.N(N_REQ)) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (xfer),
    .grant   (req_ready)
  );

  assign xfer = |req_valid;

  // Select the winner's payload; grant is one-hot so a plain overwrite works
  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = req_rd[i];
        sel_data = req_data[i];
      end
    end
  end

  // Registered write stage; x0 writes complete the handshake but are dropped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we      <= 1'b0;
      rf_rd_addr <= '0;
      rf_wdata   <= '0;
    end else if (xfer) begin
      rf_we      <= (sel_rd != '0);
      rf_rd_addr <= sel_rd;
      rf_wdata   <= sel_data;
    end else begin
      rf_we      <= 1'b0;
    end
  end

  assign issue_stall = issue_valid & busy[issue_rd];
  assign issue_set   = issue_valid & ~issue_stall & (issue_rd != '0);

  // Scoreboard next state: clear on writeback first so a same-index set wins
  always_comb begin
    busy_nxt = busy;
    if (rf_we)     busy_nxt[rf_rd_addr] = 1'b0;
    if (issue_set) busy_nxt[issue_rd]   = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register; x0 is never tracked
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed scenarios plus constrained-random
// traffic, all checked cycle by cycle against a behavioural model.
module tb_regfile_wb_arbiter;
  localparam int N = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N-1:0][4:0] req_rd;
  logic [N-1:0][31:0] req_data;
  logic              rf_we;
  logic [4:0]        rf_rd_addr;
  logic [31:0]       rf_wdata;
  logic              issue_valid;
  logic [4:0]        issue_rd;
  logic              issue_stall;
  logic [31:0]       busy;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.N_REQ(N), .XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rd(req_rd), .req_data(req_data),
    .rf_we(rf_we), .rf_rd_addr(rf_rd_addr), .rf_wdata(rf_wdata),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_stall(issue_stall), .busy(busy)
  );

  int n_chk = 0;
  int n_pass = 0;

  // reference model state
  int        m_ptr;
  bit        m_we;
  int        m_rd;
  bit [31:0] m_data;
  bit [31:0] m_busy;
  int        last_g;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic m_reset();
    m_ptr = 0; m_we = 0; m_rd = 0; m_data = 0; m_busy = 0;
  endtask

  // Called at a negedge with inputs driven: check outputs, advance model
  // across the next rising edge, return at the following negedge.
  task automatic tick();
    int g;
    bit stall;
    logic [N-1:0] er;
    #1;
    g = -1;
    er = '0;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (g < 0 && req_valid[i]) g = i;
    end
    if (g >= 0) er[g] = 1'b1;
    stall = issue_valid && m_busy[issue_rd];
    chk("ready", 64'(req_ready), 64'(er));
    chk("stall", 64'(issue_stall), 64'(stall));
    chk("rf_we", 64'(rf_we), 64'(m_we));
    chk("rf_addr", 64'(rf_rd_addr), 64'(m_rd));
    chk("rf_wdata", 64'(rf_wdata), 64'(m_data));
    chk("busy", 64'(busy), 64'(m_busy));
    last_g = g;
    if (m_we) m_busy[m_rd] = 1'b0;
    if (issue_valid && !stall && issue_rd != 0) m_busy[issue_rd] = 1'b1;
    if (g >= 0) begin
      m_ptr  = (g + 1) % N;
      m_we   = (req_rd[g] != 0);
      m_rd   = int'(req_rd[g]);
      m_data = req_data[g];
    end else begin
      m_we = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  // Assert reset in the middle of the low phase and check it acts at once
  task automatic rst_mid();
    #2 rst = 1'b1;
    #1;
    chk("rst_we", 64'(rf_we), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_addr", 64'(rf_rd_addr), 64'd0);
    chk("rst_wdata", 64'(rf_wdata), 64'd0);
    m_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_rd[0] = 5'd3;  req_data[0] = 32'hA;
    req_rd[1] = 5'd4;  req_data[1] = 32'hB;
    issue_valid = 1'b0;
    issue_rd = 5'd0;
    m_reset();
    last_g = -1;

    #3;
    chk("por_we", 64'(rf_we), 64'd0);
    chk("por_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 chk("rel_ready", 64'(req_ready), 64'(2'b01));

    // round robin: grants alternate 0,1,0,1
    for (int k = 0; k < 4; k++) begin
      #1 chk("rr_grant", 64'(req_ready), (k % 2 == 0) ? 64'(2'b01) : 64'(2'b10));
      tick();
    end

    // reset while the last rr write sits in the output stage
    chk("rr_last_we", 64'(rf_we), 64'd1);
    rst_mid();
    #1 chk("rst_ready", 64'(req_ready), 64'(2'b01));
    tick();
    req_valid = '0;
    tick();

    // x0 write: handshake completes, write dropped
    req_valid = 2'b01; req_rd[0] = 5'd0; req_data[0] = 32'hDEAD;
    tick();
    req_valid = '0;
    #1 chk("x0_we", 64'(rf_we), 64'd0);
    tick();

    // scoreboard set, stall on re-issue, clear by writeback
    issue_valid = 1'b1; issue_rd = 5'd5;
    tick();
    #1 chk("sb_stall", 64'(issue_stall), 64'd1);
    chk("sb_busy5", 64'(busy[5]), 64'd1);
    tick();
    issue_valid = 1'b0;
    req_valid = 2'b10; req_rd[1] = 5'd5; req_data[1] = 32'h55;
    tick();
    req_valid = '0;
    tick();
    issue_valid = 1'b1; issue_rd = 5'd5;
    #1 chk("sb_clr", 64'(busy[5]), 64'd0);
    chk("sb_unstall", 64'(issue_stall), 64'd0);
    tick();
    issue_valid = 1'b0;
    tick();

    // simultaneous set and clear on rd 7
    req_valid = 2'b01; req_rd[0] = 5'd7; req_data[0] = 32'h77;
    tick();
    req_valid = '0;
    issue_valid = 1'b1; issue_rd = 5'd7;
    #1 chk("sc_we", 64'(rf_we), 64'd1);
    chk("sc_pre", 64'(busy[7]), 64'd0);
    tick();
    issue_valid = 1'b0;
    #1 chk("sc_busy7", 64'(busy[7]), 64'd1);
    tick();

    // reset while rd 9 is being written
    issue_valid = 1'b1; issue_rd = 5'd9;
    tick();
    issue_valid = 1'b0;
    req_valid = 2'b01; req_rd[0] = 5'd9; req_data[0] = 32'h99;
    tick();
    req_valid = '0;
    #1 chk("mt_we", 64'(rf_we), 64'd1);
    rst_mid();
    chk("mt_busy9", 64'(busy[9]), 64'd0);
    tick();

    // random traffic honouring the valid/ready protocol
    last_g = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || last_g == i) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_rd[i]    = 5'($urandom_range(0, 7));
          req_data[i]  = $urandom;
        end
      end
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd    = 5'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

- Shares the register file's single write port between `N_REQ` writeback requesters, such as the ALU and the load unit.
- Arbitrates round-robin with a valid/ready handshake per requester.
- Registers the winning write before driving it into the register file.
- Holds a 32-entry busy scoreboard that the issue stage uses to stall on pending destinations.

## Interface
Parameters:
- `N_REQ`, 2, number of writeback requesters (2..4).
- `XLEN`, 32, data width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `req_valid` in `N_REQ`: requester i holds a write.
- `req_ready` out `N_REQ`: requester i granted this cycle (combinational).
- `req_rd` in `N_REQ`x5: destination index per requester.
- `req_data` in `N_REQ`x`XLEN`: write data per requester.
- `rf_we` out 1: register file write enable (registered).
- `rf_rd_addr` out 5: register file write index (registered).
- `rf_wdata` out `XLEN`: register file write data (registered).
- `issue_valid` in 1: issue stage dispatching an instruction that writes `issue_rd`.
- `issue_rd` in 5: destination of the dispatching instruction.
- `issue_stall` out 1: `issue_valid` & `busy[issue_rd]` (combinational).
- `busy` out 32: scoreboard bitmap; bit 0 is constant 0.

## Operation
- **Handshake.** A transfer on requester i occurs when `req_valid[i]` and `req_ready[i]` are both high at a rising edge.
  - Requester holds `req_rd`/`req_data` stable while valid and not ready.
  - Requester may not drop valid before ready.
- **Arbitration.** At most one `req_ready` bit is high per cycle.
  - Round-robin pointer `rr_ptr`: search starts at `rr_ptr`, first valid requester wins.
  - After a grant to i, `rr_ptr` becomes (i+1) mod `N_REQ`.
  - With no valid requester, `rr_ptr` holds.
- **Output stage.** On a transfer, the output register loads `rf_rd_addr`=`req_rd[i]` and `rf_wdata`=`req_data[i]`.
  - `rf_we` loads 1 when `req_rd[i]` != 0.
  - `rf_we` loads 0 for x0: the handshake still completes and the write is dropped.
  - With no transfer, `rf_we` loads 0; `rf_rd_addr`/`rf_wdata` hold their values.
- **The output stage never stalls.** `req_ready` depends only on `req_valid` and `rr_ptr`.
- **Scoreboard set.** `busy[issue_rd]` sets on an edge where `issue_valid` & !`issue_stall` & `issue_rd` != 0.
- **Stall.** When `issue_stall` is high, the issue is ignored and no bit changes.
- **Scoreboard clear.** `busy[rf_rd_addr]` clears on an edge where `rf_we`=1, the same edge the register file captures the write.
- **Set and clear on the same index, same edge:** set wins; bit stays 1.
- **Set and clear on different indices:** both apply.
- **Writeback to a non-busy register:** legal, no scoreboard effect; the clear is a no-op.
- **Reset (any time, including mid-transfer).** All state returns to reset values immediately. A write pending in the output register is discarded.
  - `rf_we`=0, `rf_rd_addr`=0, `rf_wdata`=0.
  - `busy`=0, `rr_ptr`=0.
  - `req_ready` then follows `req_valid` with requester 0 highest priority.

## Timing
- Transfer at edge k drives `rf_we` high during cycle k+1.
- The register file updates, and the busy bit clears, at edge k+1.
- Throughput: one write per cycle sustained; back-to-back grants allowed.
- Issue at edge k makes `busy` high from cycle k+1; a same-rd issue in cycle k+1 stalls.
- `issue_stall` and `req_ready` are combinational from inputs plus state, with no latency.
- Worst-case wait for a continuously valid requester: `N_REQ`-1 grants.

## Structure
- Package `regfile_pkg` holds:
  - `XLEN`=32, `REG_AW`=5, `NUM_REGS`=32.
  - typedef `reg_addr_t` (`logic [REG_AW-1:0]`).
  - typedef `reg_data_t` (`logic [XLEN-1:0]`).
- Sub-module `rr_arbiter` (parameter `N`): inputs `req`, `advance`; outputs one-hot `grant`; owns `rr_ptr`.
- The top level holds the output register, the scoreboard and the stall logic.

## Test plan
- **Reset:** assert `rst` mid-cycle with `req_valid`=2'b11. Expect `rf_we`=0 and `busy`=0 at once, then `req_ready`=2'b01 in the first cycle after release.
- **Round-robin:** both requesters valid for 4 cycles (rd 3/data 0xA, rd 4/data 0xB). Expect grants 0,1,0,1 and `rf_we` high 4 cycles with rd 3,4,3,4.
- **x0 drop:** requester 0 with rd 0, data 0xDEAD. Expect a handshake in 1 cycle and `rf_we`=0 in the following cycle.
- **Scoreboard:** issue rd 5, then re-issue rd 5 next cycle. Expect `issue_stall`=1 and `busy[5]`=1. Then write rd 5 via requester 1: `busy[5]` clears at edge k+1 and `issue_stall` drops.
- **Simultaneous set/clear:** `rf_we`=1 for rd 7 while issuing rd 7 (busy[7] was 0 before the issue). Expect `busy[7]`=1 after the edge.
- **Reset mid-transfer:** assert `rst` during the cycle `rf_we`=1 for rd 9. Expect `rf_we` low immediately and `busy[9]`=0.
